// File: rtl/sap1_loader_pkg.sv
// rtl/sap1_loader_pkg.sv - shared widths, defaults and state encoding for the SAP-1 RAM loader
package sap1_loader_pkg;

  localparam int ADDR_W           = 4;
  localparam int DATA_W           = 8;
  localparam int DEF_WORDS        = 16;
  localparam int DEF_WRITE_CYCLES = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_SETUP     = 3'd2,
    ST_WRITE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_VERIFY    = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

endpackage

// File: rtl/loader_write_timer.sv
// rtl/loader_write_timer.sv - loadable down-counter producing the active-low RAM write strobe
module loader_write_timer #(
  parameter int WRITE_CYCLES = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  output logic strobe_n,
  output logic tc
);

  localparam int CNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WRITE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_n_q, strobe_n_d;

  // The strobe is a flop output so an async clr releases it without waiting for an edge.
  always_comb begin
    cnt_d      = cnt_q;
    strobe_n_d = strobe_n_q;
    if (load) begin
      cnt_d      = LOAD_VAL;
      strobe_n_d = 1'b0;
    end else if (!strobe_n_q) begin
      if (cnt_q == '0) begin
        strobe_n_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q      <= '0;
      strobe_n_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      strobe_n_q <= strobe_n_d;
    end
  end

  assign strobe_n = strobe_n_q;
  assign tc       = !strobe_n_q && (cnt_q == '0);

endmodule

// File: rtl/sap1_ram_loader.sv
// rtl/sap1_ram_loader.sv - byte-stream programming front-end for the SAP-1 16x8 program RAM
// Optional readback verify compiled in with SAP1_LOADER_READBACK_EN.
module sap1_ram_loader
  import sap1_loader_pkg::*;
#(
  parameter int WORDS        = DEF_WORDS,
  parameter int WRITE_CYCLES = DEF_WRITE_CYCLES
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] mar_address,
  input  logic [DATA_W-1:0] memory_value,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] programmer_data,
  output logic              read_or_write,
  output logic              run_or_prog,
  output logic              loading,
  output logic              done,
  output logic              verify_error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rop_q, rop_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              loading_q, loading_d;
  logic              verr_q, verr_d;
  logic              abort_pend_q, abort_pend_d;
  logic              end_of_byte;
  logic              timer_load, timer_strobe_n, timer_tc;

  loader_write_timer #(.WRITE_CYCLES(WRITE_CYCLES)) u_write_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (timer_load),
    .strobe_n (timer_strobe_n),
    .tc       (timer_tc)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    verr_d       = verr_q;
    abort_pend_d = abort_pend_q;
    end_of_byte  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_WAIT_BYTE;
          addr_d  = '0;
          verr_d  = 1'b0;
        end
      end
      ST_WAIT_BYTE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (byte_valid && ready_q) begin
          data_d  = byte_data;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = abort ? ST_IDLE : ST_WRITE;
      // An abort during the strobe is remembered and honoured once HOLD is reached.
      ST_WRITE: begin
        if (abort) abort_pend_d = 1'b1;
        if (timer_tc) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (abort || abort_pend_q) begin
          state_d = ST_IDLE;
        end else begin
`ifdef SAP1_LOADER_READBACK_EN
          state_d = ST_VERIFY;
`else
          end_of_byte = 1'b1;
`endif
        end
      end
`ifdef SAP1_LOADER_READBACK_EN
      ST_VERIFY: begin
        if (memory_value != data_q) verr_d = 1'b1;
        if (abort) state_d = ST_IDLE;
        else       end_of_byte = 1'b1;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (end_of_byte) begin
      if (addr_q == LAST_ADDR) begin
        state_d = ST_DONE;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_WAIT_BYTE;
      end
    end

    if (state_d == ST_IDLE) abort_pend_d = 1'b0;

    ready_d   = (state_d == ST_WAIT_BYTE);
    rop_d     = (state_d == ST_IDLE) || (state_d == ST_DONE);
    done_d    = (state_d == ST_DONE);
    loading_d = (state_d != ST_IDLE);
  end

  assign timer_load = (state_q == ST_SETUP) && (state_d == ST_WRITE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      rop_q        <= 1'b1;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      loading_q    <= 1'b0;
      verr_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rop_q        <= rop_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      loading_q    <= loading_d;
      verr_q       <= verr_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign address         = rop_q ? mar_address : addr_q;
  assign programmer_data = data_q;
  assign read_or_write   = timer_strobe_n;
  assign run_or_prog     = rop_q;
  assign byte_ready      = ready_q;
  assign loading         = loading_q;
  assign done            = done_q;

`ifdef SAP1_LOADER_READBACK_EN
  assign verify_error = verr_q;
`else
  logic unused_readback;
  assign unused_readback = ^{memory_value, verr_q};
  assign verify_error    = 1'b0;
`endif

endmodule

// File: tb/tb_sap1_ram_loader.sv
// tb/tb_sap1_ram_loader.sv - directed self-checking bench for sap1_ram_loader
module tb_sap1_ram_loader;

  logic       clk = 1'b0;
  logic       clr, start, abort, byte_valid, force_ff;
  logic [7:0] byte_data;
  logic [3:0] mar_address;
  logic [7:0] memory_value;
  logic       byte_ready, read_or_write, run_or_prog, loading, done, verify_error;
  logic [3:0] address;
  logic [7:0] programmer_data;
  logic       byte_ready3, read_or_write3, run_or_prog3, loading3, done3, verify_error3;
  logic [3:0] address3;
  logic [7:0] programmer_data3;

  logic [7:0] ram [16];
  int total = 0, bad = 0, done_cnt = 0, strobe_cnt = 0;

  always #5 clk = ~clk;

  sap1_ram_loader #(.WORDS(16), .WRITE_CYCLES(2)) u_dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mar_address(mar_address), .memory_value(memory_value), .address(address),
    .programmer_data(programmer_data), .read_or_write(read_or_write),
    .run_or_prog(run_or_prog), .loading(loading), .done(done), .verify_error(verify_error)
  );

  sap1_ram_loader #(.WORDS(16), .WRITE_CYCLES(3)) u_dut3 (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready3),
    .mar_address(mar_address), .memory_value(8'h00), .address(address3),
    .programmer_data(programmer_data3), .read_or_write(read_or_write3),
    .run_or_prog(run_or_prog3), .loading(loading3), .done(done3), .verify_error(verify_error3)
  );

  assign memory_value = force_ff ? 8'hFF : ram[address];

  always @(negedge clk) begin
    if (!read_or_write) begin
      ram[address] = programmer_data;
      strobe_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 12 && !byte_ready; i++) @(negedge clk);
    chk("ready_wait", 32'(byte_ready), 1);
  endtask

  // Called at a negedge; returns at the negedge after HOLD (or VERIFY).
  task automatic send_byte(input logic [7:0] v, input logic [3:0] a, input bit last);
    byte_valid = 1'b1;
    byte_data  = v;
    wait_ready();
    @(posedge clk); #1 byte_valid = 1'b0;
    @(negedge clk);
    chk("setup_rw", 32'(read_or_write), 1);
    chk("setup_ready", 32'(byte_ready), 0);
    chk("setup_addr", 32'(address), 32'(a));
    chk("setup_data", 32'(programmer_data), 32'(v));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("write_rw", 32'(read_or_write), 0);
      chk("write_addr", 32'(address), 32'(a));
      chk("write_data", 32'(programmer_data), 32'(v));
    end
    @(negedge clk);
    chk("hold_rw", 32'(read_or_write), 1);
    chk("hold_ready", 32'(byte_ready), 0);
    chk("hold_addr", 32'(address), 32'(a));
    chk("hold_data", 32'(programmer_data), 32'(v));
`ifdef SAP1_LOADER_READBACK_EN
    @(negedge clk);
    chk("verify_rw", 32'(read_or_write), 1);
    chk("verify_rop", 32'(run_or_prog), 0);
`endif
    @(negedge clk);
    if (last) begin
      chk("done_pulse", 32'(done), 1);
      chk("done_rop", 32'(run_or_prog), 1);
    end else begin
      chk("ready_again", 32'(byte_ready), 1);
      chk("next_addr", 32'(address), 32'(a) + 1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int d0, s0;
    clr = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    byte_data = 8'h00; mar_address = 4'hA; force_ff = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_rw", 32'(read_or_write), 1);
    chk("rst_rop", 32'(run_or_prog), 1);
    chk("rst_ready", 32'(byte_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_loading", 32'(loading), 0);
    chk("rst_verr", 32'(verify_error), 0);
    chk("rst_data", 32'(programmer_data), 0);
    chk("rst_addr", 32'(address), 10);
    chk("rst3_addr", 32'(address3), 10);
    chk("rst3_data", 32'(programmer_data3), 0);
    chk("rst3_done", 32'(done3), 0);
    chk("rst3_verr", 32'(verify_error3), 0);
    clr = 1'b0;
    @(negedge clk);

    // async reset in the 2nd strobe cycle of the 3-cycle instance
    pulse_start();
    byte_valid = 1'b1; byte_data = 8'hA5;
    for (int i = 0; i < 8 && !byte_ready3; i++) @(negedge clk);
    chk("w3_ready", 32'(byte_ready3), 1);
    @(posedge clk); #1 byte_valid = 1'b0;
    for (int i = 0; i < 8 && read_or_write3; i++) @(negedge clk);
    chk("w3_strobe1", 32'(read_or_write3), 0);
    @(negedge clk);
    chk("w3_strobe2", 32'(read_or_write3), 0);
    chk("w3_rop_prog", 32'(run_or_prog3), 0);
    clr = 1'b1;
    #1;
    chk("w3_clr_rw", 32'(read_or_write3), 1);
    chk("w3_clr_rop", 32'(run_or_prog3), 1);
    chk("w3_clr_ready", 32'(byte_ready3), 0);
    chk("w3_clr_loading", 32'(loading3), 0);
    #2 clr = 1'b0;
    @(negedge clk);

    // start+abort together, then byte_valid held in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(loading), 0);
    byte_valid = 1'b1; byte_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_valid_ready", 32'(byte_ready), 0);
      chk("idle_valid_rw", 32'(read_or_write), 1);
    end
    byte_valid = 1'b0;

    // full 16-byte session, bytes (k-3)%16
    pulse_start();
    chk("sess_loading", 32'(loading), 1);
    chk("sess_rop", 32'(run_or_prog), 0);
    d0 = done_cnt; s0 = strobe_cnt;
    for (int k = 0; k < 16; k++) send_byte(8'((k + 13) % 16), 4'(k), k == 15);
    @(negedge clk);
    chk("sess_done_once", 32'(done_cnt - d0), 1);
    chk("sess_strobe_cycles", 32'(strobe_cnt - s0), 32);
    chk("sess_idle", 32'(loading), 0);
    chk("sess_done_low", 32'(done), 0);
    chk("sess_verr", 32'(verify_error), 0);
    for (int i = 0; i < 16; i++) begin
      mar_address = 4'(i);
      #1;
      chk("rb_addr", 32'(address), 32'(i));
      chk("rb_data", 32'(memory_value), 32'((i + 13) % 16));
    end
    mar_address = 4'd5; #1 chk("rb_mar5", 32'(memory_value), 2);
    mar_address = 4'd0; #1 chk("rb_mar0", 32'(memory_value), 13);
    @(negedge clk);

    // abort in the first WRITE cycle at address 3
    pulse_start();
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) send_byte(8'(8'h40 + k), 4'(k), 1'b0);
    byte_valid = 1'b1; byte_data = 8'h5C;
    wait_ready();
    @(posedge clk); #1 byte_valid = 1'b0;
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_w1_rw", 32'(read_or_write), 0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_w2_rw", 32'(read_or_write), 0);
    chk("abort_w2_loading", 32'(loading), 1);
    @(negedge clk);
    chk("abort_hold_rw", 32'(read_or_write), 1);
    chk("abort_hold_loading", 32'(loading), 1);
    @(negedge clk);
    chk("abort_idle", 32'(loading), 0);
    chk("abort_rop", 32'(run_or_prog), 1);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    mar_address = 4'd9; #1 chk("abort_mar", 32'(address), 9);
    mar_address = 4'd3; #1 chk("abort_written", 32'(memory_value), 32'h5C);
    @(negedge clk);

    // start in WAIT_BYTE ignored; abort beats byte_valid
    pulse_start();
    send_byte(8'h11, 4'd0, 1'b0);
    send_byte(8'h22, 4'd1, 1'b0);
    pulse_start();
    chk("restart_ready", 32'(byte_ready), 1);
    chk("restart_addr", 32'(address), 2);
    send_byte(8'h33, 4'd2, 1'b0);
    byte_valid = 1'b1; byte_data = 8'h99; abort = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; abort = 1'b0;
    chk("abort_wait_idle", 32'(loading), 0);
    chk("abort_wait_rw", 32'(read_or_write), 1);
    chk("abort_wait_rop", 32'(run_or_prog), 1);
    repeat (4) @(negedge clk);
    mar_address = 4'd3; #1 chk("abort_wait_nowrite", 32'(memory_value), 32'h5C);
    @(negedge clk);

`ifdef SAP1_LOADER_READBACK_EN
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      force_ff = (k == 7);
      send_byte((k == 7) ? 8'h0F : 8'(k), 4'(k), k == 15);
      force_ff = 1'b0;
      if (k == 7) chk("verr_set", 32'(verify_error), 1);
      if (k == 6) chk("verr_clean", 32'(verify_error), 0);
    end
    chk("verr_at_done", 32'(verify_error), 1);
    @(negedge clk);
    chk("verr_idle", 32'(verify_error), 1);
    pulse_start();
    chk("verr_cleared", 32'(verify_error), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
